td4_clock_ctrl: RTL and testbench

- Downstream consumer of the debounced single-cycle switch pulses; produces the CPU clock-enable for the TD4 core.
- Supports manual single-step (one enable per STEP pulse) and free-run from a prescaler (two selectable rates), toggled by a RUN pulse.
- Sits between the switch-pulse stage(s) and the TD4 datapath registers, which advance only on cpu_ce.
- Also provides a run-state LED and an 8-bit executed-step counter for display.

---
 rtl/td4_clk_pkg.sv | 34 +++
 rtl/td4_clock_ctrl_if.sv | 30 +++
 rtl/td4_prescaler.sv | 46 ++++
 rtl/td4_clock_ctrl.sv | 114 +++++++++++
 tb/tb_td4_clock_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/td4_clk_pkg.sv
// ---------------------------------------------------------------------------
// td4_clk_pkg
// Shared definitions for the TD4 clock controller:
//   state_e        - controller mode (single-step or free-run)
//   DIV_*_DEF      - default prescaler periods (1 Hz / 10 Hz at 50 MHz)
//   CE_CNT_W       - width of the executed-step counter
//   div_last       - picks the last prescaler count for the selected speed
// ---------------------------------------------------------------------------
package td4_clk_pkg;

    typedef enum logic {
        ST_STEP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DIV_SLOW_DEF = 50000000;
    localparam int DIV_FAST_DEF = 5000000;
    localparam int CNT_W_DEF    = 26;
    localparam int CE_CNT_W     = 8;

    // Select the terminal count value (period - 1) for the requested speed.
    function automatic logic [31:0] div_last(input logic fast_sel,
                                             input int   div_slow,
                                             input int   div_fast);
        logic [31:0] last_v;
        if (fast_sel) begin
            last_v = 32'(div_fast - 1);
        end else begin
            last_v = 32'(div_slow - 1);
        end
        return last_v;
    endfunction

endpackage

// File: rtl/td4_clock_ctrl_if.sv
// ---------------------------------------------------------------------------
// td4_clock_ctrl_if
// Groups the switch-pulse requests, run controls and the CPU clock-enable /
// display outputs of the TD4 clock controller.
//   master : drives step_pulse, run_toggle, speed_sel, halt; observes outputs
//   slave  : the controller itself
// ---------------------------------------------------------------------------
import td4_clk_pkg::*;

interface td4_clock_ctrl_if;

    logic                step_pulse;
    logic                run_toggle;
    logic                speed_sel;
    logic                halt;
    logic                cpu_ce;
    logic                run_led;
    logic [CE_CNT_W-1:0] ce_count;

    modport master (
        output step_pulse, run_toggle, speed_sel, halt,
        input  cpu_ce, run_led, ce_count
    );

    modport slave (
        input  step_pulse, run_toggle, speed_sel, halt,
        output cpu_ce, run_led, ce_count
    );

endinterface

// File: rtl/td4_prescaler.sv
// ---------------------------------------------------------------------------
// td4_prescaler
// Free-run rate divider. Counts while enabled and wraps to zero after the
// terminal count; clear forces the count back to zero.
//   CLK, RST      : clock, synchronous active-high reset
//   enable        : count only while high
//   clear         : synchronous clear (highest priority after reset)
//   div_sel_value : last count value of the period (period - 1)
//   terminal      : high while enabled and count >= div_sel_value
// ---------------------------------------------------------------------------
import td4_clk_pkg::*;

module td4_prescaler #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] div_sel_value,
    output logic             terminal
);

    logic [CNT_W-1:0] count_r;

    // >= rather than == so a switch to a shorter period wraps immediately.
    assign terminal = enable & (count_r >= div_sel_value);

    // Prescaler count register: clear, wrap at terminal, else advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (terminal) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/td4_clock_ctrl.sv
// ---------------------------------------------------------------------------
// td4_clock_ctrl
// Generates the TD4 CPU clock-enable from debounced switch pulses: one
// enable per STEP press, or a periodic enable from the prescaler in RUN.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : td4_clock_ctrl_if.slave
//              in : step_pulse, run_toggle (rising-edge events),
//                   speed_sel (0 slow / 1 fast), halt (suppress enables)
//              out: cpu_ce (1-cycle enable), run_led, ce_count (mod 256)
// ---------------------------------------------------------------------------
import td4_clk_pkg::*;

module td4_clock_ctrl #(
    parameter int DIV_SLOW = DIV_SLOW_DEF,
    parameter int DIV_FAST = DIV_FAST_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    td4_clock_ctrl_if.slave  bus
);

    state_e              state_r;
    state_e              state_nxt_s;
    logic                step_d_r;
    logic                run_d_r;
    logic                step_rise_s;
    logic                run_rise_s;
    logic                tick_s;
    logic                terminal_s;
    logic                presc_en_s;
    logic [CNT_W-1:0]    last_sel_s;
    logic                cpu_ce_r;
    logic                run_led_r;
    logic [CE_CNT_W-1:0] ce_count_r;

    // Rising-edge events, speed selection and prescaler enable.
    always_comb begin
        step_rise_s = bus.step_pulse & ~step_d_r;
        run_rise_s  = bus.run_toggle & ~run_d_r;
        last_sel_s  = CNT_W'(div_last(bus.speed_sel, DIV_SLOW, DIV_FAST));
        presc_en_s  = (state_r == ST_RUN);
    end

    // A run toggle always clears the prescaler: it both enters and leaves RUN.
    td4_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .CLK           (CLK),
        .RST           (RST),
        .enable        (presc_en_s),
        .clear         (run_rise_s),
        .div_sel_value (last_sel_s),
        .terminal      (terminal_s)
    );

    // Mode FSM next-state and tick generation; a toggle suppresses any tick.
    always_comb begin
        state_nxt_s = state_r;
        tick_s      = 1'b0;
        case (state_r)
            ST_STEP: begin
                if (run_rise_s) begin
                    state_nxt_s = ST_RUN;
                end else if (step_rise_s) begin
                    tick_s = 1'b1;
                end else begin
                    tick_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (run_rise_s) begin
                    state_nxt_s = ST_STEP;
                end else if (terminal_s) begin
                    tick_s = 1'b1;
                end else begin
                    tick_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_STEP;
                tick_s      = 1'b0;
            end
        endcase
    end

    // State, edge history and registered outputs; halt drops ticks outright.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_STEP;
            step_d_r   <= 1'b0;
            run_d_r    <= 1'b0;
            cpu_ce_r   <= 1'b0;
            run_led_r  <= 1'b0;
            ce_count_r <= {CE_CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            step_d_r  <= bus.step_pulse;
            run_d_r   <= bus.run_toggle;
            cpu_ce_r  <= tick_s & ~bus.halt;
            run_led_r <= (state_nxt_s == ST_RUN);
            if (tick_s & ~bus.halt) begin
                ce_count_r <= ce_count_r + {{(CE_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ce_count_r <= ce_count_r;
            end
        end
    end

    assign bus.cpu_ce   = cpu_ce_r;
    assign bus.run_led  = run_led_r;
    assign bus.ce_count = ce_count_r;

endmodule

// File: tb/tb_td4_clock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_td4_clock_ctrl
// Directed bench for td4_clock_ctrl with DIV_SLOW=8, DIV_FAST=4. Each clock
// the expected cpu_ce / run_led / ce_count is pushed to a scoreboard when the
// inputs are driven, then popped and compared one time unit after the edge.
// ---------------------------------------------------------------------------
module tb_td4_clock_ctrl;

    typedef struct packed {
        logic       ce;
        logic       led;
        logic [7:0] cnt;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] model_cnt;

    td4_clock_ctrl_if bus ();

    td4_clock_ctrl #(
        .DIV_SLOW (8),
        .DIV_FAST (4),
        .CNT_W    (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Inputs are already applied; ce/led are the values expected after the edge.
    task automatic tick(input logic ce, input logic led, input string tag);
        exp_t e;
        exp_t got;
        if (RST) begin
            model_cnt = 8'd0;
        end else if (ce) begin
            model_cnt = model_cnt + 8'd1;
        end
        e.ce  = ce;
        e.led = led;
        e.cnt = model_cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        vectors += 3;
        assert (bus.cpu_ce === got.ce) else begin
            miscompares++;
            $error("FAIL %s cpu_ce observed=%0b expected=%0b", tag, bus.cpu_ce, got.ce);
        end
        assert (bus.run_led === got.led) else begin
            miscompares++;
            $error("FAIL %s run_led observed=%0b expected=%0b", tag, bus.run_led, got.led);
        end
        assert (bus.ce_count === got.cnt) else begin
            miscompares++;
            $error("FAIL %s ce_count observed=%0d expected=%0d", tag, bus.ce_count, got.cnt);
        end
    endtask

    initial begin
        bus.step_pulse = 1'b0;
        bus.run_toggle = 1'b0;
        bus.speed_sel  = 1'b0;
        bus.halt       = 1'b0;
        model_cnt      = 8'd0;
        RST            = 1'b1;
        tick(1'b0, 1'b0, "reset");
        RST = 1'b0;

        // Three single-cycle steps, 10 cycles apart.
        repeat (3) begin
            bus.step_pulse = 1'b1;
            tick(1'b1, 1'b0, "step");
            bus.step_pulse = 1'b0;
            repeat (9) tick(1'b0, 1'b0, "step_gap");
        end

        // Held step yields exactly one enable; speed_sel in STEP does nothing.
        RST = 1'b1;
        tick(1'b0, 1'b0, "reset2");
        RST = 1'b0;
        bus.step_pulse = 1'b1;
        tick(1'b1, 1'b0, "held_step");
        bus.speed_sel = 1'b1;
        repeat (19) tick(1'b0, 1'b0, "held_step_hi");
        bus.speed_sel  = 1'b0;
        bus.step_pulse = 1'b0;
        tick(1'b0, 1'b0, "held_step_rel");

        // Slow free-run: first enable 8 cycles after entry, then every 8.
        bus.run_toggle = 1'b1;
        tick(1'b0, 1'b1, "run_enter");
        bus.run_toggle = 1'b0;
        repeat (5) begin
            repeat (7) tick(1'b0, 1'b1, "run_slow_gap");
            tick(1'b1, 1'b1, "run_slow_ce");
        end
        // A step press in RUN is ignored; count reaches 6 then speed goes fast.
        bus.step_pulse = 1'b1;
        tick(1'b0, 1'b1, "run_step_ignored");
        bus.step_pulse = 1'b0;
        repeat (5) tick(1'b0, 1'b1, "run_to_six");
        bus.speed_sel = 1'b1;
        tick(1'b1, 1'b1, "fast_wrap");
        repeat (2) begin
            repeat (3) tick(1'b0, 1'b1, "run_fast_gap");
            tick(1'b1, 1'b1, "run_fast_ce");
        end

        // Halt drops enables but the prescaler keeps its cadence.
        bus.halt = 1'b1;
        repeat (16) tick(1'b0, 1'b1, "halt");
        bus.halt = 1'b0;
        repeat (2) begin
            repeat (3) tick(1'b0, 1'b1, "resume_gap");
            tick(1'b1, 1'b1, "resume_ce");
        end

        // Leave RUN, then simultaneous step+toggle in STEP: toggle wins.
        bus.run_toggle = 1'b1;
        tick(1'b0, 1'b0, "run_exit");
        bus.run_toggle = 1'b0;
        tick(1'b0, 1'b0, "step_idle");
        bus.step_pulse = 1'b1;
        bus.run_toggle = 1'b1;
        tick(1'b0, 1'b1, "simul_toggle");
        bus.step_pulse = 1'b0;
        bus.run_toggle = 1'b0;
        repeat (3) tick(1'b0, 1'b1, "simul_run_gap");
        // Reset on the terminal-count cycle cancels the pending enable.
        RST = 1'b1;
        tick(1'b0, 1'b0, "rst_mid_run");
        RST = 1'b0;
        tick(1'b0, 1'b0, "post_rst");

        // 257 steps wrap the counter to 1.
        repeat (257) begin
            bus.step_pulse = 1'b1;
            tick(1'b1, 1'b0, "wrap_step");
            bus.step_pulse = 1'b0;
            tick(1'b0, 1'b0, "wrap_gap");
        end
        vectors++;
        assert (bus.ce_count === 8'd1) else begin
            miscompares++;
            $error("FAIL wrap_final ce_count observed=%0d expected=1", bus.ce_count);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
